// File: rtl/tt_exerciser_pkg.sv
// tt_exerciser_pkg
// Shared definitions for the TinyTapeout pin exerciser:
//   - state_t    : exerciser run states
//   - LFSR_MASK  : Galois feedback mask for the 16-bit stimulus LFSR
//   - MISR_POLY  : feedback polynomial for the ACTIVE-phase signature
//   - OE_ALL_IN / OE_ALL_OUT : expected uio_oe values per phase
//   - misr_next  : one signature compaction step
package tt_exerciser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DUT_RST,
    PASSTHRU,
    ACTIVE,
    DONE
  } state_t;

  localparam logic [15:0] LFSR_MASK  = 16'hB400;
  localparam logic [15:0] MISR_POLY  = 16'h1021;
  localparam logic [7:0]  OE_ALL_IN  = 8'h00;
  localparam logic [7:0]  OE_ALL_OUT = 8'hFF;

  // Shift the signature left, fold the polynomial back in when the MSB
  // falls off, then absorb the 16 bits of DUT output for this cycle.
  function automatic logic [15:0] misr_next(input logic [15:0] sig,
                                            input logic [15:0] din);
    return {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ din;
  endfunction

endpackage

// File: rtl/tt_lfsr16.sv
// tt_lfsr16
// 16-bit right-shifting Galois LFSR used as the stimulus source.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset, returns the register to SEED
//   load  : reload SEED (has priority over step)
//   step  : advance the sequence by one position
//   state : current LFSR contents
module tt_lfsr16
  import tt_exerciser_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  output logic [15:0] state
);

  // The register only moves when asked to: reload wins over step so a
  // fresh run always starts from the seed, and the feedback mask is
  // applied whenever a one shifts out of the bottom.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (step) begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_MASK : 16'h0000);
    end
  end

endmodule

// File: rtl/tt_pin_exerciser.sv
// tt_pin_exerciser
// Harness-side initiator for a TinyTapeout user module. It resets the user
// design, runs a PASSTHRU phase (ui_in[0]=0, outputs must mirror uio_in with
// uio fully tristated) and an ACTIVE phase (ui_in[0]=1, uio must be fully
// driven, outputs folded into a signature), then reports the result.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   start                : run request, honoured only in IDLE or DONE
//   busy, done, pass     : run status (pass valid while done)
//   err_count            : mismatching vectors, saturating at 255
//   signature            : MISR over ACTIVE-phase {uio_out, uo_out}
//   dut_rst_n, dut_ena   : control pins toward the user design
//   dut_ui_in, dut_uio_in: stimulus pins toward the user design
//   dut_uo_out, dut_uio_out, dut_uio_oe : responses from the user design
module tt_pin_exerciser
  import tt_exerciser_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 256,
  parameter int unsigned RST_CYCLES  = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [15:0] signature,
  output logic        dut_rst_n,
  output logic        dut_ena,
  output logic [7:0]  dut_ui_in,
  output logic [7:0]  dut_uio_in,
  input  logic [7:0]  dut_uo_out,
  input  logic [7:0]  dut_uio_out,
  input  logic [7:0]  dut_uio_oe
);

  localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] LAST_RST = 16'(RST_CYCLES - 1);

  state_t      state;
  logic        launch;
  logic [15:0] cnt;
  logic [15:0] lfsr;
  logic        lfsr_load;
  logic        lfsr_step;
  logic        last_vec;
  logic        vec_bad;
  logic [7:0]  err_next;
  logic        unused_lfsr_lsb;

  // Bit 0 of the LFSR is replaced by the phase flag on ui_in[0].
  assign unused_lfsr_lsb = lfsr[0];

  tt_lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (lfsr_load),
    .step (lfsr_step),
    .state(lfsr)
  );

  // Per-cycle decisions: when to reseed or advance the LFSR and whether the
  // vector currently on the pins produced a bad response. The LFSR steps on
  // exactly the edges that load a new vector onto the pins, so the pins
  // always show the value the LFSR held just before that edge.
  always_comb begin
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    vec_bad   = 1'b0;
    last_vec  = (cnt == LAST_VEC);
    case (state)
      IDLE, DONE: begin
        lfsr_load = start && !launch;
      end
      DUT_RST: begin
        lfsr_step = (cnt == LAST_RST);
      end
      PASSTHRU: begin
        lfsr_step = 1'b1;
        vec_bad   = (dut_uo_out != dut_uio_in) ||
                    (dut_uio_oe != OE_ALL_IN) ||
                    (dut_uio_out != 8'h00);
      end
      ACTIVE: begin
        lfsr_step = !last_vec;
        vec_bad   = (dut_uio_oe != OE_ALL_OUT);
      end
      default: begin
        lfsr_load = 1'b0;
      end
    endcase
    err_next = (vec_bad && (err_count != 8'hFF)) ? err_count + 8'd1 : err_count;
  end

  // Run sequencer with registered outputs. A start request first spends one
  // cycle in IDLE with 'launch' set (results cleared, LFSR reseeded) so busy
  // rises one edge after start is sampled; the whole run then follows that
  // offset: DUT reset for RST_CYCLES, NUM_VECTORS passthrough vectors and
  // NUM_VECTORS active vectors, with no stalls. The final ACTIVE vector is
  // left on the pins once the run is over.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      launch     <= 1'b0;
      cnt        <= 16'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 8'd0;
      signature  <= 16'd0;
      dut_rst_n  <= 1'b0;
      dut_ena    <= 1'b0;
      dut_ui_in  <= 8'd0;
      dut_uio_in <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            launch    <= 1'b0;
            state     <= DUT_RST;
            busy      <= 1'b1;
            dut_rst_n <= 1'b0;
            dut_ena   <= 1'b1;
            cnt       <= 16'd0;
          end else begin
            dut_rst_n <= 1'b0;
            dut_ena   <= 1'b0;
            if (start) begin
              launch    <= 1'b1;
              err_count <= 8'd0;
              signature <= 16'd0;
            end
          end
        end
        DUT_RST: begin
          if (cnt == LAST_RST) begin
            cnt        <= 16'd0;
            state      <= PASSTHRU;
            dut_rst_n  <= 1'b1;
            dut_ui_in  <= {lfsr[7:1], 1'b0};
            dut_uio_in <= lfsr[15:8];
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        PASSTHRU: begin
          err_count  <= err_next;
          dut_uio_in <= lfsr[15:8];
          if (last_vec) begin
            cnt       <= 16'd0;
            state     <= ACTIVE;
            dut_ui_in <= {lfsr[7:1], 1'b1};
          end else begin
            cnt       <= cnt + 16'd1;
            dut_ui_in <= {lfsr[7:1], 1'b0};
          end
        end
        ACTIVE: begin
          err_count <= err_next;
          signature <= misr_next(signature, {dut_uio_out, dut_uo_out});
          if (last_vec) begin
            cnt   <= 16'd0;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 8'd0);
          end else begin
            cnt        <= cnt + 16'd1;
            dut_ui_in  <= {lfsr[7:1], 1'b1};
            dut_uio_in <= lfsr[15:8];
          end
        end
        DONE: begin
          if (start) begin
            state     <= IDLE;
            launch    <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            dut_rst_n <= 1'b0;
            dut_ena   <= 1'b0;
            err_count <= 8'd0;
            signature <= 16'd0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
